// File: rtl/tdm_demux8.sv
// Eight-lane TDM demultiplexer: slot words framed by a sync on slot 0 are steered
// into per-lane registers, and each complete frame is published as one snapshot.
module tdm_demux8 #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   din,
    input  logic               din_valid,
    input  logic               din_sync,
    output logic [8*WIDTH-1:0] lane_out,
    output logic [7:0]         lane_strobe,
    output logic [8*WIDTH-1:0] frame_out,
    output logic               frame_valid,
    output logic               sync_err,
    output logic               locked
);
    localparam int NUM_LANES = 8;

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t     state, nstate;
    logic [2:0] slot, nslot;
    logic       wr, err, done;
    logic [2:0] wr_lane;

    logic [NUM_LANES-1:0][WIDTH-1:0] lane_q, frame_q;

    always_comb begin
        nstate  = state;
        nslot   = slot;
        wr      = 1'b0;
        wr_lane = 3'd0;
        err     = 1'b0;
        done    = 1'b0;
        if (din_valid) begin
            if (state == HUNT) begin
                if (din_sync) begin
                    wr     = 1'b1;
                    nslot  = 3'd1;
                    nstate = LOCKED;
                end
            end else if (din_sync) begin
                // A sync mid-frame abandons the partial frame and restarts at lane 0.
                wr    = 1'b1;
                nslot = 3'd1;
                err   = (slot != 3'd0);
            end else if (slot == 3'd0) begin
                err    = 1'b1;
                nstate = HUNT;
            end else begin
                wr      = 1'b1;
                wr_lane = slot;
                nslot   = slot + 3'd1;
                done    = (slot == 3'd7);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            slot        <= 3'd0;
            lane_strobe <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= nstate;
            slot        <= nslot;
            lane_strobe <= wr ? (8'd1 << wr_lane) : 8'd0;
            frame_valid <= done;
            sync_err    <= err;
            locked      <= (nstate == LOCKED);
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        tdm_lane #(.WIDTH(WIDTH)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .din     (din),
            .wr      (wr && (wr_lane == 3'(k))),
            .cap     (done),
            .lane_q  (lane_q[k]),
            .frame_q (frame_q[k])
        );
    end

    assign lane_out  = lane_q;
    assign frame_out = frame_q;
endmodule

// One lane: live register plus frame snapshot; a snapshot taken on the same edge
// as this lane's write captures the incoming word rather than the stale value.
module tdm_lane #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr,
    input  logic             cap,
    output logic [WIDTH-1:0] lane_q,
    output logic [WIDTH-1:0] frame_q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q  <= '0;
            frame_q <= '0;
        end else begin
            if (wr)  lane_q  <= din;
            if (cap) frame_q <= wr ? din : lane_q;
        end
    end
endmodule

// File: tb/tb_tdm_demux8.sv
// Directed plus randomized bench for tdm_demux8 against an array-based frame model.
module tb_tdm_demux8;
    localparam int W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [W-1:0]     din = '0;
    logic             din_valid = 1'b0;
    logic             din_sync = 1'b0;
    logic [8*W-1:0]   lane_out;
    logic [7:0]       lane_strobe;
    logic [8*W-1:0]   frame_out;
    logic             frame_valid;
    logic             sync_err;
    logic             locked;

    int checks = 0;
    int failures = 0;

    // reference model
    logic [W-1:0] m_lane [8];
    logic [W-1:0] m_frame[8];
    int           m_slot;
    bit           m_locked;
    logic [7:0]   m_strobe;
    bit           m_fv, m_err;

    tdm_demux8 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_sync(din_sync),
        .lane_out(lane_out), .lane_strobe(lane_strobe), .frame_out(frame_out),
        .frame_valid(frame_valid), .sync_err(sync_err), .locked(locked)
    );

    always #5 clk = ~clk;

    function automatic logic [8*W-1:0] pack(input logic [W-1:0] a[8]);
        logic [8*W-1:0] v;
        for (int k = 0; k < 8; k++) v[k*W +: W] = a[k];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [8*W-1:0] obs, input logic [8*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":lane_out"},    lane_out,    pack(m_lane));
        chk({tag, ":frame_out"},   frame_out,   pack(m_frame));
        chk({tag, ":lane_strobe"}, {120'd0, lane_strobe}, {120'd0, m_strobe});
        chk({tag, ":frame_valid"}, {127'd0, frame_valid}, {127'd0, m_fv});
        chk({tag, ":sync_err"},    {127'd0, sync_err},    {127'd0, m_err});
        chk({tag, ":locked"},      {127'd0, locked},      {127'd0, m_locked});
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            m_lane[k]  = '0;
            m_frame[k] = '0;
        end
        m_slot = 0; m_locked = 0; m_strobe = '0; m_fv = 0; m_err = 0;
    endtask

    task automatic model_step(input bit v, input bit s, input logic [W-1:0] d);
        m_strobe = '0; m_fv = 0; m_err = 0;
        if (!v) return;
        if (!m_locked) begin
            if (s) begin
                m_lane[0] = d; m_strobe = 8'h01; m_slot = 1; m_locked = 1;
            end
        end else if (s) begin
            m_err = (m_slot != 0);
            m_lane[0] = d; m_strobe = 8'h01; m_slot = 1;
        end else if (m_slot == 0) begin
            m_err = 1; m_locked = 0;
        end else begin
            m_lane[m_slot] = d;
            m_strobe = 8'(1 << m_slot);
            if (m_slot == 7) begin
                for (int k = 0; k < 8; k++) m_frame[k] = m_lane[k];
                m_fv = 1;
                m_slot = 0;
            end else begin
                m_slot++;
            end
        end
    endtask

    task automatic step(input string tag, input bit v, input bit s, input logic [W-1:0] d);
        @(negedge clk);
        din_valid = v; din_sync = s; din = d;
        @(posedge clk);
        #1;
        model_step(v, s, d);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1; din_valid = 0; din_sync = 0;
        #2;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic frame(input string tag, input logic [W-1:0] base, input int gap);
        for (int k = 0; k < 8; k++) begin
            step(tag, 1, k == 0, base + W'(k));
            for (int g = 0; g < gap; g++) step(tag, 0, 1, 16'hDEAD);
        end
    endtask

    initial begin
        logic [8*W-1:0] expv;
        logic [8*W-1:0] gapped_snap;
        int             nfv;

        model_reset();
        rst = 1;
        #1;
        check_all("reset");
        #10;
        rst = 0;

        // single back-to-back frame, confirm walking strobe and one frame_valid
        nfv = 0;
        for (int k = 0; k < 8; k++) begin
            step("frame1", 1, k == 0, 16'h1000 + W'(k));
            chk("frame1:strobe_walk", {120'd0, lane_strobe}, {120'd0, 8'(1 << k)});
            if (frame_valid) nfv++;
        end
        chk("frame1:fv_count", 128'(nfv), 128'd1);
        for (int k = 0; k < 8; k++) expv[k*W +: W] = 16'h1000 + W'(k);
        chk("frame1:snapshot", frame_out, expv);
        step("idle", 0, 0, 16'h0);

        // hunt: unsynced words dropped after a reset
        do_reset("reset2");
        for (int i = 0; i < 3; i++) step("hunt_drop", 1, 0, 16'hAAAA);
        frame("hunt_frame", 16'h2000, 0);
        for (int k = 0; k < 8; k++) expv[k*W +: W] = 16'h2000 + W'(k);
        chk("hunt:snapshot", frame_out, expv);

        // short frame then resync
        for (int k = 0; k < 5; k++) step("short", 1, k == 0, 16'h3000 + W'(k));
        step("short_resync", 1, 1, 16'h4000);
        chk("short:sync_err", {127'd0, sync_err}, 128'd1);
        for (int k = 1; k < 8; k++) step("short_next", 1, 0, 16'h4000 + W'(k));
        for (int k = 0; k < 8; k++) expv[k*W +: W] = 16'h4000 + W'(k);
        chk("short:snapshot", frame_out, expv);

        // missing sync on a 9th word
        step("long_9th", 1, 0, 16'h5555);
        chk("long:locked", {127'd0, locked}, 128'd0);
        chk("long:lane0", 128'(lane_out[W-1:0]), 128'h4000);
        frame("relock", 16'h4800, 0);

        // gapped frame must match back-to-back result
        frame("gapped", 16'h7000, 2);
        gapped_snap = frame_out;
        frame("b2b", 16'h7000, 0);
        chk("gapped:vs_b2b", gapped_snap, frame_out);

        // async reset mid-frame, no clock edge in between
        for (int k = 0; k < 5; k++) step("pre_rst", 1, k == 0, 16'h6100 + W'(k));
        #2;
        rst = 1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 0;
        frame("post_rst", 16'h6000, 0);
        chk("post_rst:fv", {127'd0, frame_valid}, 128'd1);

        // randomized traffic including gaps and framing faults
        for (int i = 0; i < 600; i++) begin
            bit v, s;
            v = ($urandom % 4) != 0;
            s = (m_slot == 0) ? (($urandom % 10) != 0) : (($urandom % 12) == 0);
            if (!v) s = $urandom % 2;
            step("rand", v, s, W'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
